// File: rtl/drq_irq_if.sv
// drq_irq_if: request/interrupt signals between framemanager, drq_irq and the MCU pins.
// master drives the request pulse and chip select; slave (drq_irq) drives the interrupt side.
interface drq_irq_if #(
  parameter int c_ovf_w = 8
);
  logic               i_drq;
  logic               i_cs;
  logic               o_int;
  logic               o_pending;
  logic [c_ovf_w-1:0] o_overruns;
  logic               o_timeout;

  modport master (
    output i_drq, i_cs,
    input  o_int, o_pending, o_overruns, o_timeout
  );

  modport slave (
    input  i_drq, i_cs,
    output o_int, o_pending, o_overruns, o_timeout
  );
endinterface

// File: rtl/drq_irq.sv
// drq_irq: turns single-cycle frame data requests into a level interrupt for the host MCU.
// The MCU acknowledges by pulling chip select low; one further request can be queued,
// anything beyond that is counted as an overrun (saturating).
// Optional feature macro LAMP_IRQ_TIMEOUT_EN: when defined, an unacknowledged interrupt is
// dropped after c_timeout cycles, o_timeout pulses, and the interrupt is re-raised after the
// minimum low time. When undefined the interrupt holds until acknowledged.
module drq_irq #(
  parameter int c_timeout = 20000,
  parameter int c_min_low = 4,
  parameter int c_ovf_w   = 8
) (
  input logic      i_clk,
  input logic      i_rst,
  drq_irq_if.slave bus
);

  localparam int                 c_gap_w    = $clog2(c_min_low + 1);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(c_min_low - 1);
`ifdef LAMP_IRQ_TIMEOUT_EN
  localparam int                 c_tmr_w    = $clog2(c_timeout + 1);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(c_timeout - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_BUSY   = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_drq;
  logic               w_cs;
  logic               r_cs_meta;
  logic               r_cs_sync;
  logic               r_cs_prev;
  logic               w_cs_fall;
  logic               w_cs_rise;
  logic [c_gap_w-1:0] r_gap_cnt;
  logic               r_int;
  logic               r_pending;
  logic               w_pending_next;
  logic               w_pending_clr;
  logic [c_ovf_w-1:0] r_overruns;
  logic [c_ovf_w-1:0] w_overruns_next;
  logic               w_ovf_inc;
  logic               w_drq_queue;
  logic               w_drq_drop;
  logic               r_timeout;
  logic               w_timeout_next;
`ifdef LAMP_IRQ_TIMEOUT_EN
  logic [c_tmr_w-1:0] r_timer;
  logic               r_rearm;
  logic               w_rearm_next;
`endif

  assign w_drq = bus.i_drq;
  assign w_cs  = bus.i_cs;

  // Two-flop synchronizer for the asynchronous chip select plus a delayed copy for edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cs_meta <= 1'b1;
      r_cs_sync <= 1'b1;
      r_cs_prev <= 1'b1;
    end else begin
      r_cs_meta <= w_cs;
      r_cs_sync <= r_cs_meta;
      r_cs_prev <= r_cs_sync;
    end
  end

  assign w_cs_fall = r_cs_prev & ~r_cs_sync;
  assign w_cs_rise = ~r_cs_prev & r_cs_sync;

  // Next state, plus classification of an incoming request (queue it, drop it, or take it directly)
  always_comb begin
    w_state_next   = r_state;
    w_drq_queue    = 1'b0;
    w_drq_drop     = 1'b0;
    w_pending_clr  = 1'b0;
    w_timeout_next = 1'b0;
`ifdef LAMP_IRQ_TIMEOUT_EN
    w_rearm_next   = r_rearm;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_drq) w_state_next = S_ASSERT;
      end
      S_ASSERT: begin
        if (w_cs_fall) begin
          // The MCU is taking the current frame now, so a new request can wait in the queue.
          w_state_next = S_BUSY;
          w_drq_queue  = w_drq;
        end else begin
          // Current frame not serviced yet: another request cannot be honoured.
          w_drq_drop = w_drq;
`ifdef LAMP_IRQ_TIMEOUT_EN
          if (r_timer == c_tmr_last) begin
            w_state_next   = S_GAP;
            w_timeout_next = 1'b1;
            w_rearm_next   = 1'b1;
          end
`endif
        end
      end
      S_BUSY: begin
        w_drq_queue = w_drq;
        if (w_cs_rise) w_state_next = S_GAP;
      end
      S_GAP: begin
        w_drq_queue = w_drq;
        if (r_gap_cnt == c_gap_last) begin
`ifdef LAMP_IRQ_TIMEOUT_EN
          if (r_rearm) begin
            w_state_next = S_ASSERT;
            w_rearm_next = 1'b0;
          end else
`endif
          if (r_pending) begin
            w_state_next  = S_ASSERT;
            w_pending_clr = 1'b1;
          end else if (w_drq) begin
            // A request arriving on the way back to idle is served straight away.
            w_state_next = S_ASSERT;
            w_drq_queue  = 1'b0;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Queue slot and saturating overrun counter updates
  always_comb begin
    w_pending_next  = r_pending & ~w_pending_clr;
    w_ovf_inc       = w_drq_drop;
    w_overruns_next = r_overruns;
    if (w_drq_queue) begin
      if (r_pending) w_ovf_inc = 1'b1;
      else           w_pending_next = 1'b1;
    end
    if (w_ovf_inc && (r_overruns != {c_ovf_w{1'b1}})) begin
      w_overruns_next = r_overruns + 1'b1;
    end
  end

  // State, registered outputs and the minimum-low-time counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_int      <= 1'b0;
      r_pending  <= 1'b0;
      r_overruns <= '0;
      r_timeout  <= 1'b0;
      r_gap_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_int      <= (w_state_next == S_ASSERT);
      r_pending  <= w_pending_next;
      r_overruns <= w_overruns_next;
      r_timeout  <= w_timeout_next;
      // Counts cycles spent in GAP; held at zero elsewhere so every GAP entry starts fresh.
      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
      else                  r_gap_cnt <= '0;
    end
  end

`ifdef LAMP_IRQ_TIMEOUT_EN
  // Assertion timer (zero outside ASSERT, hence cleared on every entry) and the re-arm flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timer <= '0;
      r_rearm <= 1'b0;
    end else begin
      r_rearm <= w_rearm_next;
      if (r_state == S_ASSERT) r_timer <= r_timer + 1'b1;
      else                     r_timer <= '0;
    end
  end
`endif

  assign bus.o_int      = r_int;
  assign bus.o_pending  = r_pending;
  assign bus.o_overruns = r_overruns;
  assign bus.o_timeout  = r_timeout;

endmodule
